word_align_lock: RTL and testbench
==================================

# word_align_lock

Parametrised frame-locking word aligner for the deserialised PHY receive stream. It finds a sync word at any of W bit offsets, then confirms it recurs every FRAME_LEN words before declaring lock. Once locked it tolerates isolated sync misses before falling back to hunting. It sits between the PHY deserialiser and the frame decoder and also provides the decoder's start-of-frame marker.

## Interface
- W, 16: word width in bits, at least 2
- SYNC, 16'hF731: sync pattern, W bits
- FRAME_LEN, 8: words per frame including the sync word, at least 2
- LOCK_CNT, 3: consecutive in-place syncs, including the first hit, needed to lock, at least 1
- UNLOCK_CNT, 4: consecutive missed syncs while locked that force a return to HUNT, at least 1
- CLK  input  1  clock
- RSTX  input  1  reset, asynchronous, active-low
- PHY_INIT  input  1  synchronous restart to HUNT
- DIPUSH  input  1  DIN valid this cycle
- DIN  input  W  raw word; the MSB is the earliest bit
- DOPUSH  output  1  DOUT valid
- DOUT  output  W  aligned word
- SOF  output  1  DOUT is a frame's sync word
- ALIGNED  output  1  FSM in LOCKED
- OFFSET  output  $clog2(W)  current bit offset
- STATE  output  2  debug: 0 HUNT, 1 VERIFY, 2 LOCKED

## Operation
- Shift register sh, 2W-1 bits.
  - nx = {sh[W-2:0], DIN}.
  - sh <= nx on DIPUSH only.
- Matches: hit[k] = (nx[k+W-1:k] == SYNC) for k = 0..W-1. Only evaluated on DIPUSH cycles.
- Registers: state, off, pos (0..FRAME_LEN-1), good (lock counter), miss (miss counter). Every FSM action below happens only on a DIPUSH cycle without PHY_INIT.
- HUNT, any hit:
  - off <= lowest k with hit[k]; pos <= 0; good <= 1.
  - Next state is VERIFY, or LOCKED if LOCK_CNT == 1.
  - No hit: stay in HUNT.
- VERIFY and LOCKED: the word that arrives when pos == FRAME_LEN-1 is the expected sync. pos <= 0 on that word, otherwise pos+1.
- VERIFY, expected-sync word:
  - hit[off]: good+1; on reaching LOCK_CNT go to LOCKED with miss <= 0.
  - Miss: go to HUNT. No re-search on that word.
- LOCKED, expected-sync word:
  - hit[off]: miss <= 0.
  - Miss: miss+1; on reaching UNLOCK_CNT go to HUNT, otherwise stay in LOCKED and keep off.
- Hits at other offsets, or at unexpected positions, are ignored in VERIFY and LOCKED. Lock never jumps directly to a new offset.
- PHY_INIT, any cycle:
  - state <= HUNT; off, pos, good, miss <= 0.
  - Wins over a simultaneous DIPUSH for FSM purposes. sh still shifts and DOPUSH/DOUT are still produced, using off = 0 and SOF = 0.
- Output datapath:
  - DOUT <= nx[off_n+W-1:off_n], where off_n is the offset after this cycle's update, so the first-hit word comes out aligned.
  - DOUT holds its value when DIPUSH = 0.
- SOF <= DIPUSH and (HUNT hit, or the expected-sync word in VERIFY/LOCKED regardless of match). SOF is 0 under PHY_INIT.
- ALIGNED, OFFSET and STATE are registered copies of state/off, updated with the same edge as DOUT.

## Timing
- Latency DIN to DOUT is 1 cycle. DOPUSH <= DIPUSH every cycle, independent of state.
- Lock with the first hit on push N: LOCKED is entered on push N+(LOCK_CNT-1)*FRAME_LEN, and ALIGNED rises on the following edge.
- Unlock: ALIGNED falls on the edge after the UNLOCK_CNT-th consecutive missed sync.
- Reset values:
  - sh, DOUT, OFFSET, pos, good, miss = 0.
  - DOPUSH, SOF, ALIGNED = 0.
  - STATE = HUNT.
- Reset mid-frame drops lock immediately and asynchronously.
- Gaps: DIPUSH = 0 cycles freeze everything except DOPUSH = 0 and SOF = 0. pos counts pushes, not cycles.
- pos wraps FRAME_LEN-1 to 0; miss and good never exceed their thresholds.

## Test plan
- W=16, SYNC=F731, FRAME_LEN=8, LOCK_CNT=3. Bitstream delayed by 5 bits, sync every 8th word, first hit on push 10 -> OFFSET=5, STATE=VERIFY after push 10, LOCKED after push 26, ALIGNED=1 the next cycle, SOF on pushes 10/18/26/34, DOUT=F731 on each.
- Locked, then 3 corrupted syncs followed by a good one -> ALIGNED stays 1, miss clears. Then 4 consecutive corrupted syncs -> ALIGNED=0 after the 4th, STATE=HUNT.
- VERIFY with the second sync corrupted -> STATE=HUNT, ALIGNED never rises. A fresh sync at offset 9 -> OFFSET=9.
- Two patterns aligned at offsets 3 and 11 in one word -> OFFSET=3 chosen.
- Locked, PHY_INIT asserted together with DIPUSH -> next cycle STATE=HUNT, ALIGNED=0, OFFSET=0, DOPUSH=1, SOF=0.
- Random DIPUSH gaps (about 50% duty) on the lock stream -> same lock push count as the gap-free case, no spurious SOF, DOUT sequence identical.

Source files
------------

// File: rtl/word_align_lock.sv
// rtl/word_align_lock.sv - frame-locking word aligner: sync hunt, in-place verify, tolerant lock
module word_align_lock #(
  parameter int           W          = 16,
  parameter logic [W-1:0] SYNC       = 16'hF731,
  parameter int           FRAME_LEN  = 8,
  parameter int           LOCK_CNT   = 3,
  parameter int           UNLOCK_CNT = 4
) (
  input  logic                 CLK,
  input  logic                 RSTX,
  input  logic                 PHY_INIT,
  input  logic                 DIPUSH,
  input  logic [W-1:0]         DIN,
  output logic                 DOPUSH,
  output logic [W-1:0]         DOUT,
  output logic                 SOF,
  output logic                 ALIGNED,
  output logic [$clog2(W)-1:0] OFFSET,
  output logic [1:0]           STATE
);

  localparam int OW = $clog2(W);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   off_q, off_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [GW-1:0]   good_q, good_d;
  logic [MW-1:0]   miss_q, miss_d;
  // Only the low W-1 bits of the history ever reach a candidate window.
  logic [W-2:0]    sh_q, sh_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            dopush_q, dopush_d;
  logic            sof_q, sof_d;
  logic            aligned_q, aligned_d;

  logic [2*W-2:0]  nx;
  logic [W-1:0]    hit;
  logic            any_hit;
  logic [OW-1:0]   low_k;
  logic            exp_sync;
  logic            hit_off;

  // Candidate window and sync matches at every offset; lowest matching offset wins
  always_comb begin
    nx      = {sh_q, DIN};
    hit     = '0;
    for (int k = 0; k < W; k++) begin
      hit[k] = (nx[k +: W] == SYNC);
    end
    any_hit = |hit;
    low_k   = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (hit[k]) low_k = OW'(k);
    end
    exp_sync = (pos_q == PW'(FRAME_LEN - 1));
    hit_off  = hit[off_q];
  end

  // Next-state logic: hunt / verify / locked plus the aligned output word
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    pos_d    = pos_q;
    good_d   = good_q;
    miss_d   = miss_q;
    sh_d     = sh_q;
    dout_d   = dout_q;
    dopush_d = DIPUSH;
    sof_d    = 1'b0;

    if (DIPUSH) sh_d = nx[W-2:0];

    if (PHY_INIT) begin
      state_d = HUNT;
      off_d   = '0;
      pos_d   = '0;
      good_d  = '0;
      miss_d  = '0;
    end else if (DIPUSH) begin
      case (state_q)
        HUNT: begin
          if (any_hit) begin
            off_d  = low_k;
            pos_d  = '0;
            good_d = GW'(1);
            sof_d  = 1'b1;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              miss_d  = '0;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          pos_d = exp_sync ? '0 : pos_q + PW'(1);
          if (exp_sync) begin
            sof_d = 1'b1;
            if (hit_off) begin
              good_d = good_q + GW'(1);
              if (good_q == GW'(LOCK_CNT - 1)) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          pos_d = exp_sync ? '0 : pos_q + PW'(1);
          if (exp_sync) begin
            sof_d = 1'b1;
            if (hit_off) begin
              miss_d = '0;
            end else if (miss_q == MW'(UNLOCK_CNT - 1)) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Use the post-update offset so the first-hit word already comes out aligned.
    if (DIPUSH) dout_d = nx[off_d +: W];
    aligned_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q   <= HUNT;
      off_q     <= '0;
      pos_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      dopush_q  <= 1'b0;
      sof_q     <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      pos_q     <= pos_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      dopush_q  <= dopush_d;
      sof_q     <= sof_d;
      aligned_q <= aligned_d;
    end
  end

  assign DOPUSH  = dopush_q;
  assign DOUT    = dout_q;
  assign SOF     = sof_q;
  assign ALIGNED = aligned_q;
  assign OFFSET  = off_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_word_align_lock.sv
// tb/tb_word_align_lock.sv - directed checks for word_align_lock
module tb_word_align_lock;

  logic        CLK = 1'b0;
  logic        RSTX = 1'b0;
  logic        phy_init = 1'b0;
  logic        dipush = 1'b0;
  logic [15:0] din = '0;
  logic        dopush;
  logic [15:0] dout;
  logic        sof;
  logic        aligned;
  logic [3:0]  offset;
  logic [1:0]  state;

  logic        phy_init2 = 1'b0;
  logic        dipush2 = 1'b0;
  logic [15:0] din2 = '0;
  logic        dopush2;
  logic [15:0] dout2;
  logic        sof2;
  logic        aligned2;
  logic [3:0]  offset2;
  logic [1:0]  state2;

  word_align_lock u_dut (
    .CLK(CLK), .RSTX(RSTX), .PHY_INIT(phy_init), .DIPUSH(dipush), .DIN(din),
    .DOPUSH(dopush), .DOUT(dout), .SOF(sof), .ALIGNED(aligned),
    .OFFSET(offset), .STATE(state)
  );

  word_align_lock #(.SYNC(16'hAAAA), .LOCK_CNT(1)) u_dut2 (
    .CLK(CLK), .RSTX(RSTX), .PHY_INIT(phy_init2), .DIPUSH(dipush2), .DIN(din2),
    .DOPUSH(dopush2), .DOUT(dout2), .SOF(sof2), .ALIGNED(aligned2),
    .OFFSET(offset2), .STATE(state2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         push;
    logic [1:0] st;
    logic       al;
    logic [3:0] off;
  } ckpt_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        sbits [0:2047];
  logic [15:0] corrupt_mask;
  ckpt_t       ta [8];
  ckpt_t       tb [9];
  ckpt_t       tc [3];

  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s push=%0d got=%0h expected=%0h", name, p, act, exp);
    end
  endtask

  function automatic logic [15:0] payload(input int f, input int w);
    return {8'h00, 1'b0, 3'(f), 1'b0, 3'(w)};
  endfunction

  function automatic logic [15:0] lword(input int l);
    if (l % 8 == 0) return corrupt_mask[l / 8] ? 16'hF730 : 16'hF731;
    return payload(l / 8, l % 8);
  endfunction

  task automatic clear_stream();
    for (int i = 0; i < 2048; i++) sbits[i] = 1'b0;
  endtask

  task automatic put(input int pos, input logic [15:0] v);
    for (int i = 0; i < 16; i++) sbits[pos + i] = v[15 - i];
  endtask

  // Frames start at bit 139: the first sync completes in push 10 at bit offset 5.
  task automatic build(input int nframes);
    clear_stream();
    for (int l = 0; l < nframes * 8; l++) put(139 + 16 * l, lword(l));
  endtask

  function automatic logic [15:0] raw(input int p);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15 - i] = sbits[(p - 1) * 16 + i];
    return w;
  endfunction

  function automatic logic [15:0] exp_dout(input int p);
    return (p < 10) ? raw(p) : lword(p - 10);
  endfunction

  function automatic logic [1:0] exp_state(input int p);
    if (p < 10) return 2'd0;
    if (p < 26) return 2'd1;
    return 2'd2;
  endfunction

  task automatic do_push(input logic [15:0] d, input logic pi);
    dipush = 1'b1;
    din = d;
    phy_init = pi;
    @(posedge CLK);
    #1;
    dipush = 1'b0;
    phy_init = 1'b0;
  endtask

  task automatic idle();
    dipush = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTX = 1'b0;
    dipush = 1'b0;
    phy_init = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTX = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          p;
    int          cyc;
    logic [15:0] last;

    ta[0] = '{9,  2'd0, 1'b0, 4'd0};
    ta[1] = '{10, 2'd1, 1'b0, 4'd5};
    ta[2] = '{17, 2'd1, 1'b0, 4'd5};
    ta[3] = '{18, 2'd1, 1'b0, 4'd5};
    ta[4] = '{25, 2'd1, 1'b0, 4'd5};
    ta[5] = '{26, 2'd2, 1'b1, 4'd5};
    ta[6] = '{27, 2'd2, 1'b1, 4'd5};
    ta[7] = '{41, 2'd2, 1'b1, 4'd5};

    tb[0] = '{26, 2'd2, 1'b1, 4'd5};
    tb[1] = '{34, 2'd2, 1'b1, 4'd5};
    tb[2] = '{42, 2'd2, 1'b1, 4'd5};
    tb[3] = '{50, 2'd2, 1'b1, 4'd5};
    tb[4] = '{58, 2'd2, 1'b1, 4'd5};
    tb[5] = '{66, 2'd2, 1'b1, 4'd5};
    tb[6] = '{74, 2'd2, 1'b1, 4'd5};
    tb[7] = '{82, 2'd2, 1'b1, 4'd5};
    tb[8] = '{90, 2'd0, 1'b0, 4'd5};

    tc[0] = '{10, 2'd1, 1'b0, 4'd5};
    tc[1] = '{18, 2'd0, 1'b0, 4'd5};
    tc[2] = '{24, 2'd1, 1'b0, 4'd9};

    // Reset state
    do_reset();
    chk("rst_dopush", 0, dopush, 0);
    chk("rst_sof", 0, sof, 0);
    chk("rst_aligned", 0, aligned, 0);
    chk("rst_state", 0, state, 0);
    chk("rst_offset", 0, offset, 0);
    chk("rst_dout", 0, dout, 0);

    // Gap-free lock at offset 5, then PHY_INIT on an expected-sync push
    corrupt_mask = '0;
    build(6);
    for (int q = 1; q <= 41; q++) begin
      do_push(raw(q), 1'b0);
      chk("A_dopush", q, dopush, 1);
      chk("A_sof", q, sof, (q >= 10 && (q - 10) % 8 == 0));
      chk("A_dout", q, dout, exp_dout(q));
      for (int i = 0; i < 8; i++) begin
        if (ta[i].push == q) begin
          chk("A_state", q, state, ta[i].st);
          chk("A_aligned", q, aligned, ta[i].al);
          chk("A_offset", q, offset, ta[i].off);
        end
      end
    end
    do_push(raw(42), 1'b1);
    chk("E_state", 42, state, 0);
    chk("E_aligned", 42, aligned, 0);
    chk("E_offset", 42, offset, 0);
    chk("E_dopush", 42, dopush, 1);
    chk("E_sof", 42, sof, 0);
    chk("E_dout", 42, dout, raw(42));
    idle();
    chk("E_idle_dopush", 43, dopush, 0);
    chk("E_idle_dout", 43, dout, raw(42));

    // Miss tolerance: 3 misses, a good sync, then 4 misses to unlock
    do_reset();
    corrupt_mask = 16'h07B8;
    build(11);
    for (int q = 1; q <= 90; q++) begin
      do_push(raw(q), 1'b0);
      for (int i = 0; i < 9; i++) begin
        if (tb[i].push == q) begin
          chk("B_state", q, state, tb[i].st);
          chk("B_aligned", q, aligned, tb[i].al);
        end
      end
      if (q == 50) begin
        chk("B_sof_bad_sync", q, sof, 1);
        chk("B_dout_bad_sync", q, dout, 16'hF730);
      end
    end

    // Verify failure then fresh sync at offset 9
    do_reset();
    clear_stream();
    put(139, 16'hF731);
    put(139 + 128, 16'hF730);
    put(359, 16'hF731);
    for (int q = 1; q <= 30; q++) begin
      do_push(raw(q), 1'b0);
      chk("C_aligned", q, aligned, 0);
      chk("C_sof", q, sof, (q == 10 || q == 18 || q == 24));
      for (int i = 0; i < 3; i++) begin
        if (tc[i].push == q) begin
          chk("C_state", q, state, tc[i].st);
          chk("C_offset", q, offset, tc[i].off);
        end
      end
      if (q == 18) chk("C_dout_bad", q, dout, 16'hF730);
      if (q == 24) chk("C_dout_new", q, dout, 16'hF731);
    end

    // Several matching offsets in one window, single-sync lock on second instance
    do_reset();
    dipush2 = 1'b1;
    din2 = 16'h0555;
    @(posedge CLK);
    #1;
    chk("D_state_first", 1, state2, 0);
    chk("D_sof_first", 1, sof2, 0);
    din2 = 16'h5550;
    @(posedge CLK);
    #1;
    dipush2 = 1'b0;
    chk("D_offset", 2, offset2, 3);
    chk("D_state", 2, state2, 2);
    chk("D_aligned", 2, aligned2, 1);
    chk("D_sof", 2, sof2, 1);
    chk("D_dout", 2, dout2, 16'hAAAA);
    chk("D_dopush", 2, dopush2, 1);

    // Random push gaps on the clean lock stream
    do_reset();
    corrupt_mask = '0;
    build(6);
    p = 0;
    cyc = 0;
    last = '0;
    while (p < 34 && cyc < 400) begin
      cyc++;
      if ($urandom_range(0, 1) == 0) begin
        idle();
        chk("F_idle_dopush", p, dopush, 0);
        chk("F_idle_sof", p, sof, 0);
        chk("F_idle_dout", p, dout, last);
        chk("F_idle_state", p, state, exp_state(p));
      end else begin
        p++;
        do_push(raw(p), 1'b0);
        last = exp_dout(p);
        chk("F_dopush", p, dopush, 1);
        chk("F_sof", p, sof, (p >= 10 && (p - 10) % 8 == 0));
        chk("F_dout", p, dout, last);
        chk("F_state", p, state, exp_state(p));
        chk("F_aligned", p, aligned, (p >= 26));
      end
    end
    chk("F_push_count", p, p, 34);

    // Asynchronous reset mid-cycle while locked
    #3;
    RSTX = 1'b0;
    #1;
    chk("R_aligned", p, aligned, 0);
    chk("R_state", p, state, 0);
    chk("R_offset", p, offset, 0);
    chk("R_dout", p, dout, 0);
    @(posedge CLK);
    #1;
    RSTX = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
